// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8: eight-client round-robin arbiter with hold limit and one-cycle turnaround gap
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   req[7:0]            level-sensitive request per client
//   gnt[7:0]            registered one-hot grant, zero when idle
//   gnt_idx[2:0]        registered index of the grant holder, zero when idle
//   gnt_valid           high while a grant is held
//   preempt             one-cycle pulse in the gap after a hold-limit release
module rr_arbiter_8 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic [2:0] gnt_idx,
    output logic       gnt_valid,
    output logic       preempt
);
    typedef enum logic [1:0] {IDLE, GRANT, PAUSE} state_t;
    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d, idx_q, idx_d, off;
    logic [7:0] hold_q, hold_d, gnt_q, gnt_d, rot, lim;
    logic       valid_q, valid_d, preempt_q, preempt_d, rel_n, rel_f;
    assign lim = 8'(MAX_HOLD);
    // rotate so the pointer position sits at bit 0; the lowest set bit is then the winner offset
    always_comb begin
        rot = 8'({req, req} >> ptr_q);
        off = '0;
        for (int i = 7; i >= 0; i--) if (rot[i]) off = 3'(i);
    end
    assign rel_n = !req[idx_q];
    assign rel_f = hold_q == lim && (req & ~gnt_q) != '0;
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        idx_d     = idx_q;
        gnt_d     = gnt_q;
        valid_d   = valid_q;
        preempt_d = 1'b0;
        case (state_q)
            IDLE: if (req != '0) begin
                state_d = GRANT;
                idx_d   = ptr_q + off;
                gnt_d   = 8'd1 << idx_d;
                valid_d = 1'b1;
                hold_d  = 8'd1;
            end
            GRANT: if (rel_n || rel_f) begin
                state_d   = PAUSE;
                ptr_d     = idx_q + 3'd1;
                idx_d     = '0;
                gnt_d     = '0;
                valid_d   = 1'b0;
                hold_d    = '0;
                preempt_d = !rel_n;
            end else begin
                hold_d = hold_q == lim ? hold_q : hold_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            hold_q    <= '0;
            idx_q     <= '0;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            idx_q     <= idx_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            preempt_q <= preempt_d;
        end
    end
    assign gnt       = gnt_q;
    assign gnt_idx   = idx_q;
    assign gnt_valid = valid_q;
    assign preempt   = preempt_q;
endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-requester round-robin arbiter that shares one downstream resource (a bus or datapath selected through the 3-to-8 decoder) among eight clients. It picks one winner, holds the grant until the winner releases or a hold limit expires, then inserts a turnaround gap before the next grant. It outputs the winner both as a 3-bit index, which drives the decoder select, and as an 8-bit one-hot grant.

## Interface
- MAX_HOLD, 16, maximum grant cycles before forced release when others are waiting; legal range 2..255.
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- req  input  8  request per client; level-sensitive, held while the client wants or uses the resource
- gnt  output  8  one-hot grant; equals the decode of gnt_idx while gnt_valid=1, else 8'h00
- gnt_idx  output  3  index of the current grant holder; 0 when not granting
- gnt_valid  output  1  high while a grant is active
- preempt  output  1  one-cycle pulse marking a forced release by the hold limit

## Operation
- All outputs are registered.
- Internal state:
  - state ∈ {IDLE, GRANT, PAUSE}
  - ptr[2:0], the round-robin start point
  - hold_cnt[7:0]
- Reset (rst high at an edge) forces state=IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_idx=0, gnt_valid=0, preempt=0.
- Reset overrides everything, including an active grant. No release pulse is generated.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise the winner is the first set bit in cyclic order ptr, ptr+1, …, ptr+7, computed modulo 8 with 7 wrapping to 0.
  - Register gnt_idx=winner, gnt=one-hot(winner), gnt_valid=1, hold_cnt=1, and go to GRANT.
- GRANT, evaluated each edge:
  - Normal release: if req[gnt_idx]==0, release with preempt=0.
  - Forced release: if hold_cnt==MAX_HOLD and (req with bit gnt_idx masked) != 0, release with preempt=1.
  - Otherwise stay in GRANT and set hold_cnt = min(hold_cnt+1, MAX_HOLD). The counter saturates, so a lone requester keeps the grant indefinitely.
  - If both release conditions hold on the same edge, it is a normal release (preempt=0).
  - On any release: set ptr = gnt_idx+1 (mod 8), clear gnt, gnt_idx and gnt_valid, and go to PAUSE.
- PAUSE:
  - Lasts exactly one cycle with all grant outputs 0, then goes to IDLE unconditionally.
  - preempt is high only during this cycle, and only after a forced release.
- The one-hot invariant is that gnt has at most one bit set, at all times.
- Requests from a client whose grant was just released take no priority. The pointer guarantees every other pending client is served before it.

## Timing
- Grant latency: a req sampled high at edge k while in IDLE produces gnt/gnt_valid visible after edge k. This is a 1-cycle latency from request to grant.
- Release latency:
  - A release sampled at edge m drops gnt after edge m.
  - PAUSE occupies the cycle between edges m and m+1, and IDLE is entered at edge m+1.
  - The next winner is sampled at edge m+2.
  - So the minimum gap between consecutive grants is 2 cycles with gnt=0.
- Maximum grant length with contention is MAX_HOLD cycles of gnt_valid=1.
- Worst-case wait for a continuously requesting client is 7×(MAX_HOLD+2) cycles.
- Requests that rise and fall entirely between sampling edges are not seen. Clients hold req until they are granted.

## Test plan
- Reset: drive rst=1 for 2 edges with req=8'hFF. Required: gnt=8'h00, gnt_idx=0, gnt_valid=0, preempt=0, and the first grant after rst falls goes to client 0.
- Single client:
  - Stimulus: req=8'h08 for 5 cycles, then 8'h00.
  - Required: gnt=8'h08 and gnt_idx=3 one cycle after req rises; gnt=8'h00 one cycle after req drops; preempt never high.
- Rotation: req=8'hFF, with each client dropping its bit 3 cycles after being granted and re-raising it in the PAUSE cycle. Required: grant order 0,1,2,3,4,5,6,7,0 with two zero-gnt cycles between grants.
- Hold limit (MAX_HOLD=16):
  - Stimulus: req[2] held permanently; req[5] raised 4 cycles into the grant.
  - Required: gnt=8'h04 for exactly 16 cycles, then preempt=1 for one cycle, then gnt=8'h20 two cycles after the release.
  - A lone req[2] with no contention keeps the grant for more than 100 cycles with no preempt.
- Pointer wrap: grant client 6, release it, then present req=8'h41. Required: ptr=7, so the next grant goes to 0 (gnt=8'h01), not 6.
- Reset mid-grant: while gnt=8'h10, assert rst for one edge. Required: all outputs are 0 after that edge; then req=8'h81 grants client 0.
